// File: rtl/ps2_kb_writer.sv
// rtl/ps2_kb_writer.sv - PS/2 keyboard receiver publishing key-event words to the KB_INFO slot
module ps2_kb_writer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] kb_wraddr,
    output logic [31:0] kb_wrdata,
    output logic        kb_we,
    output logic        frame_err
);

    localparam logic [31:0] KB_INFO_OFFSET = 32'h0050_0000;
    localparam int          TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIM  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          data_bit;
    logic [TW-1:0] idle_cnt;
    logic          timeout;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic          parity_ok;
    logic          ext;
    logic          brk;
    logic [15:0]   evt_cnt;

    assign kb_wraddr = KB_INFO_OFFSET;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign parity_ok = ^{shift, par_bit};

    // A partial frame is abandoned once the line has been quiet too long.
    assign timeout = (state != IDLE) && (idle_cnt == TIMEOUT_LIM);

    // Two-stage synchronisers plus a registered falling-edge detect; data is delayed to match.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            fall      <= 1'b0;
            data_bit  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            fall      <= clk_prev & ~clk_sync[1];
            data_bit  <= data_sync[1];
        end
    end

    // Quiet-line counter: cleared by every edge, counts only mid-frame, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (fall) begin
            idle_cnt <= '0;
        end else if ((state != IDLE) && (idle_cnt != TIMEOUT_LIM)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Frame FSM, prefix decoder and registered event/error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            par_bit   <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            evt_cnt   <= 16'h0000;
            kb_wrdata <= 32'h0000_0000;
            kb_we     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            kb_we     <= 1'b0;
            frame_err <= 1'b0;
            if (timeout) begin
                state     <= IDLE;
                shift     <= 8'h00;
                ext       <= 1'b0;
                brk       <= 1'b0;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        // A high start bit is line noise; stay put.
                        if (!data_bit) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= data_bit;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (parity_ok && data_bit) begin
                            if (shift == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (shift == 8'hF0) begin
                                brk <= 1'b1;
                            end else begin
                                // The word carries the post-increment count so the CPU sees a change.
                                kb_wrdata <= {evt_cnt + 16'd1, 6'b000000, brk, ext, shift};
                                evt_cnt   <= evt_cnt + 16'd1;
                                kb_we     <= 1'b1;
                                ext       <= 1'b0;
                                brk       <= 1'b0;
                            end
                        end else begin
                            shift     <= 8'h00;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_kb_writer.sv
// tb/tb_ps2_kb_writer.sv - randomized and directed self-checking bench for ps2_kb_writer
module tb_ps2_kb_writer;

    localparam int HALF = 6;
    localparam int GAP  = 20;
    localparam logic [31:0] ADDR = 32'h0050_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] kb_wraddr;
    logic [31:0] kb_wrdata;
    logic        kb_we;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] ev_q[$];
    logic [31:0] exp_q[$];
    int          err_pulses = 0;
    int          exp_errs = 0;
    logic        we_d = 1'b0;

    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;
    logic [15:0] m_cnt = 16'h0000;

    ps2_kb_writer #(.TIMEOUT_CYCLES(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kb_wraddr (kb_wraddr),
        .kb_wrdata (kb_wrdata),
        .kb_we     (kb_we),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling clock edge.
    always @(negedge clk) begin
        if (we_d) begin
            checks++;
            if (kb_we !== 1'b0) begin
                errors++;
                $display("FAIL we_width: kb_we=%b required 0 after a strobe", kb_we);
            end
        end
        we_d = kb_we;
        if (kb_we === 1'b1) ev_q.push_back(kb_wrdata);
        if (frame_err === 1'b1) err_pulses++;
    end

    // Key-event reference: prefixes accumulate, other bytes emit a word, discards clear prefixes.
    function automatic void model_frame(input logic [7:0] b, input logic good);
        if (!good) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            exp_errs++;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            m_cnt = m_cnt + 16'd1;
            exp_q.push_back({m_cnt, 6'b000000, m_brk, m_ext, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        tick(GAP);
        model_frame(b, !flip_par && !bad_stop);
    endtask

    task automatic clear_obs();
        ev_q.delete();
        exp_q.delete();
        err_pulses = 0;
        exp_errs = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(5);
        @(negedge clk);
        checks++; if (kb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", kb_we); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", frame_err); end
        checks++; if (kb_wrdata !== 32'h0) begin errors++; $display("FAIL reset_wrdata: got %h required 00000000", kb_wrdata); end
        checks++; if (kb_wraddr !== ADDR) begin errors++; $display("FAIL reset_addr: got %h required %h", kb_wraddr, ADDR); end
        rst = 1'b0;
        tick(10);
        clear_obs();
    endtask

    task automatic test_make();
        logic [31:0] got;
        clear_obs();
        send_frame(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        got = (ev_q.size() > 0) ? ev_q[0] : 32'hxxxx_xxxx;
        checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL make_count: got %0d strobes required 1", ev_q.size()); end
        checks++; if (got !== 32'h0001_001C) begin errors++; $display("FAIL make_word: got %h required 0001001c", got); end
        checks++; if (kb_wraddr !== ADDR) begin errors++; $display("FAIL make_addr: got %h required %h", kb_wraddr, ADDR); end
        checks++; if (err_pulses != 0) begin errors++; $display("FAIL make_err: got %0d pulses required 0", err_pulses); end
        checks++; if (kb_wrdata !== 32'h0001_001C) begin errors++; $display("FAIL make_hold: got %h required 0001001c", kb_wrdata); end
    endtask

    task automatic test_break();
        logic [31:0] got;
        clear_obs();
        send_frame(8'hF0, 1'b0, 1'b0);
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL break_prefix: got %0d strobes required 0", ev_q.size()); end
        send_frame(8'h1C, 1'b0, 1'b0);
        got = (ev_q.size() > 0) ? ev_q[0] : 32'hxxxx_xxxx;
        checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL break_count: got %0d strobes required 1", ev_q.size()); end
        checks++; if (got !== 32'h0002_021C) begin errors++; $display("FAIL break_word: got %h required 0002021c", got); end
    endtask

    task automatic test_ext_release();
        logic [31:0] got;
        clear_obs();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        got = (ev_q.size() > 0) ? ev_q[0] : 32'hxxxx_xxxx;
        checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL extrel_count: got %0d strobes required 1", ev_q.size()); end
        checks++; if (got !== 32'h0003_0375) begin errors++; $display("FAIL extrel_word: got %h required 00030375", got); end
        send_frame(8'h75, 1'b0, 1'b0);
        got = (ev_q.size() > 1) ? ev_q[1] : 32'hxxxx_xxxx;
        checks++; if (got !== 32'h0004_0075) begin errors++; $display("FAIL extrel_clear: got %h required 00040075", got); end
    endtask

    task automatic test_parity_error();
        logic [31:0] got;
        clear_obs();
        send_frame(8'h1C, 1'b1, 1'b0);
        checks++; if (err_pulses != 1) begin errors++; $display("FAIL par_err: got %0d pulses required 1", err_pulses); end
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL par_nowe: got %0d strobes required 0", ev_q.size()); end
        checks++; if (kb_wrdata !== 32'h0004_0075) begin errors++; $display("FAIL par_hold: got %h required 00040075", kb_wrdata); end
        send_frame(8'h1C, 1'b0, 1'b0);
        got = (ev_q.size() > 0) ? ev_q[0] : 32'hxxxx_xxxx;
        checks++; if (got !== 32'h0005_001C) begin errors++; $display("FAIL par_next: got %h required 0005001c", got); end
    endtask

    task automatic test_stop_error();
        logic [31:0] got;
        clear_obs();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        checks++; if (err_pulses != 1) begin errors++; $display("FAIL stop_err: got %0d pulses required 1", err_pulses); end
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL stop_nowe: got %0d strobes required 0", ev_q.size()); end
        send_frame(8'h1C, 1'b0, 1'b0);
        got = (ev_q.size() > 0) ? ev_q[0] : 32'hxxxx_xxxx;
        checks++; if (got !== 32'h0006_001C) begin errors++; $display("FAIL stop_next: got %h required 0006001c", got); end
    endtask

    task automatic test_timeout();
        logic [31:0] got;
        clear_obs();
        send_frame(8'hE0, 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
        ps2_data = 1'b1;
        tick(150);
        model_frame(8'h00, 1'b0);
        checks++; if (err_pulses != 1) begin errors++; $display("FAIL timeout_err: got %0d pulses required 1", err_pulses); end
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL timeout_nowe: got %0d strobes required 0", ev_q.size()); end
        send_frame(8'h29, 1'b0, 1'b0);
        got = (ev_q.size() > 0) ? ev_q[0] : 32'hxxxx_xxxx;
        checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL timeout_count: got %0d strobes required 1", ev_q.size()); end
        checks++; if (got !== 32'h0007_0029) begin errors++; $display("FAIL timeout_word: got %h required 00070029", got); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         pick;
        logic       fp;
        logic       fs;
        logic [31:0] got;
        clear_obs();
        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 9);
            if (pick < 2) b = 8'hE0;
            else if (pick < 4) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            fp = ($urandom_range(0, 9) == 0);
            fs = !fp && ($urandom_range(0, 9) == 0);
            send_frame(b, fp, fs);
        end
        checks++; if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d strobes required %0d", ev_q.size(), exp_q.size()); end
        checks++; if (err_pulses != exp_errs) begin errors++; $display("FAIL rand_errs: got %0d pulses required %0d", err_pulses, exp_errs); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < ev_q.size()) ? ev_q[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL rand_word[%0d]: got %h required %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        clear_obs();
        send_frame(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        dut.evt_cnt = 16'hFFFE;
        m_cnt = 16'hFFFE;
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        got = (ev_q.size() > 0) ? ev_q[0] : 32'hxxxx_xxxx;
        checks++; if (got !== 32'hFFFF_001C) begin errors++; $display("FAIL wrap_top: got %h required ffff001c", got); end
        got = (ev_q.size() > 1) ? ev_q[1] : 32'hxxxx_xxxx;
        checks++; if (got !== 32'h0000_001C) begin errors++; $display("FAIL wrap_zero: got %h required 0000001c", got); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] got;
        clear_obs();
        send_frame(8'hF0, 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'(8'h1C >> i));
        ps2_data = 1'b1;
        tick(3);
        rst = 1'b1;
        m_cnt = 16'h0000;
        m_ext = 1'b0;
        m_brk = 1'b0;
        tick(4);
        @(negedge clk);
        checks++; if (kb_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b required 0", kb_we); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b required 0", frame_err); end
        checks++; if (kb_wrdata !== 32'h0) begin errors++; $display("FAIL rstmid_wrdata: got %h required 00000000", kb_wrdata); end
        checks++; if (kb_wraddr !== ADDR) begin errors++; $display("FAIL rstmid_addr: got %h required %h", kb_wraddr, ADDR); end
        rst = 1'b0;
        tick(200);
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL rstmid_nowe: got %0d strobes required 0", ev_q.size()); end
        checks++; if (err_pulses != 0) begin errors++; $display("FAIL rstmid_noerr: got %0d pulses required 0", err_pulses); end
        send_frame(8'h1C, 1'b0, 1'b0);
        got = (ev_q.size() > 0) ? ev_q[0] : 32'hxxxx_xxxx;
        checks++; if (got !== 32'h0001_001C) begin errors++; $display("FAIL rstmid_next: got %h required 0001001c", got); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext_release();
        test_parity_error();
        test_stop_error();
        test_timeout();
        test_random();
        test_wrap();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kb_writer.md
# ps2_kb_writer

Receives PS/2 keyboard frames, decodes make/break and extended prefixes, and publishes one 32-bit key-event word per completed key code into the keyboard-info slot of the memory map (KB_INFO_OFFSET, 0x00500000) through the `kb_wraddr`/`kb_wrdata`/`kb_we` write port. It sits directly upstream of the memory map. The CPU polls the word and detects new events by the embedded event counter, because the slot holds only the latest event.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- `clk` in 1: system clock; the single clock of the block.
- `rst` in 1: reset; synchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `kb_wraddr` out 32: write address; constant 0x00500000.
- `kb_wrdata` out 32: event word.
  - [7:0] scancode
  - [8] extended (E0 seen)
  - [9] released (F0 seen)
  - [15:10] 0
  - [31:16] event counter
- `kb_we` out 1: one-cycle write strobe.
- `frame_err` out 1: one-cycle pulse on a discarded frame.

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through two flip-flops. A falling edge is detected when the prior synced `ps2_clk` = 1 and the current synced `ps2_clk` = 0. Data is sampled only in the detect cycle.
- **Frame FSM:** IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on an edge with data = 0 (start bit), go to DATA with bit counter = 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: 8 edges, LSB first, shifted into the byte register. Leave after bit counter = 7.
  - PARITY: capture one bit. Parity is odd: the XOR of the 8 data bits and the parity bit must be 1.
  - STOP: capture the stop bit, which must be 1. If parity and stop are both good, pass the byte to the decoder; otherwise pulse `frame_err`. Return to IDLE in either case.
- **Decoder flags** `ext` and `brk`:
  - Byte 0xE0 sets `ext`.
  - Byte 0xF0 sets `brk`.
  - Any other byte produces an event: `kb_wrdata` = {cnt+1, 6'b0, brk, ext, byte}, `kb_we` = 1 for one cycle, `cnt` increments, then both flags clear.
  - Prefix order does not matter: E0 F0 x and F0 E0 x both give ext = brk = 1.
- **Discarded frame** (parity error, stop error, or timeout): clears `ext`, `brk` and the shift register, and pulses `frame_err`. The event counter is untouched.
- **Timeout:** an idle counter resets on every falling edge. If the FSM is outside IDLE and the counter reaches `TIMEOUT_CYCLES`, the FSM aborts to IDLE. The idle counter saturates and does not count in IDLE.
- **Event counter:** 16 bits, wraps 0xFFFF → 0x0000.
- **`kb_wrdata` hold:** holds the last event value between strobes.
- **Not supported:** host-to-device transmission; `ps2_clk` and `ps2_data` are never driven.

## Timing
- **Reset values:** `kb_we` = 0, `frame_err` = 0, `kb_wrdata` = 0, event counter = 0, `ext` = `brk` = 0, FSM = IDLE, sync flops = 1, idle counter = 0. `kb_wraddr` is constant 0x00500000 at all times.
- **Edge latency:** falling edge on the `ps2_clk` pin → detect cycle is 3 `clk` edges later (2 sync stages plus the edge register).
- **Event latency:** `kb_we` and the new `kb_wrdata` are registered and appear in the cycle after the stop-bit detect cycle. `kb_we` is high for exactly one cycle.
- **Error latency:** `frame_err` pulses in the cycle after the stop-bit detect cycle, or in the cycle after the timeout is reached.
- **Event rate:** at most one `kb_we` per frame, so strobes are at least 11 PS/2 clock periods apart. There is no back-pressure and no buffering; the memory map accepts every strobe.
- **Reset mid-frame:** the partial frame is dropped and pending prefixes are lost. The first frame after reset must start with a fresh start bit.
- **Same-cycle reset and event:** `rst` wins and `kb_we` stays 0.

## Test plan
- **Make code:** after reset, send frame 0x1C (parity 0). Expect one `kb_we` pulse, `kb_wrdata` = 0x0001001C, `kb_wraddr` = 0x00500000, `frame_err` never high.
- **Break code:** send F0 then 1C. Expect no strobe after F0, then exactly one strobe with `kb_wrdata` = 0x0002021C.
- **Extended release:** send E0, F0, 75. Expect one strobe, `kb_wrdata` = 0x00030375. Then send 75 alone; expect 0x00040075, showing the flags cleared.
- **Parity error:** send 0x1C with the parity bit flipped. Expect a `frame_err` pulse, no `kb_we`, counter unchanged. The next valid 0x1C gives counter +1.
- **Timeout:** send a start bit plus 4 data bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES` (set to 100 in the bench). Expect a `frame_err` pulse and the FSM in IDLE. A following valid 0x29 gives a single strobe with [7:0] = 0x29.
- **Counter wrap and reset:** force 65536 events; the counter reads 0x0000 on the last one. Assert `rst` during bit 3 of a frame; expect all outputs at reset values and no strobe from that frame.
